// File: rtl/lsu_dcache_arbiter.sv
// rtl/lsu_dcache_arbiter.sv - two-requester DCache port arbiter with ordered response routing
`timescale 1ns/1ps

package lsu_dcache_pkg;
    typedef struct packed {
        logic [31:0] vaddr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        is_store;
    } iq_lsu_pkg_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } lsu_iq_pkg_t;
endpackage

module lsu_dcache_arbiter
    import lsu_dcache_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_LEN         = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        iq_valid_i,
    output logic        iq_ready_o,
    input  iq_lsu_pkg_t iq_req_i,
    input  logic        cm_valid_i,
    output logic        cm_ready_o,
    input  iq_lsu_pkg_t cm_req_i,
    output logic        dc_valid_o,
    input  logic        dc_ready_i,
    output iq_lsu_pkg_t dc_req_o,
    input  logic        dc_resp_valid_i,
    output logic        dc_resp_ready_o,
    input  lsu_iq_pkg_t dc_resp_i,
    output logic        iq_resp_valid_o,
    input  logic        iq_resp_ready_i,
    output logic        cm_resp_valid_o,
    input  logic        cm_resp_ready_i,
    output lsu_iq_pkg_t resp_o,
    output logic        busy_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_LEN-1:0] MAX_CNT  = CNT_LEN'(MAX_OUTSTANDING);

    // Tag FIFO: owner 0 = issue queue, 1 = commit path
    logic [MAX_OUTSTANDING-1:0] tag_owner;
    logic [MAX_OUTSTANDING-1:0] tag_drop;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_LEN-1:0]         cnt;
    logic                       rr_q;
    logic                       stage_owner;

    logic stage_free;
    logic grant;
    logic winner;
    logic cancel;
    logic pop;
    logic fifo_empty;
    logic head_owner;
    logic head_drop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? LAST_IDX : p - 1'b1;
    endfunction

    always_comb begin
        stage_free = !dc_valid_o || dc_ready_i;
        grant      = stage_free && (cnt < MAX_CNT) && !flush && (iq_valid_i || cm_valid_i);
        winner     = (iq_valid_i && cm_valid_i) ? rr_q : cm_valid_i;
        iq_ready_o = grant && !winner;
        cm_ready_o = grant && winner;
        // An unsent IQ request can be withdrawn; once handshaking it must be dropped instead
        cancel     = flush && dc_valid_o && !stage_owner && !dc_ready_i;
    end

    always_comb begin
        fifo_empty      = (cnt == '0);
        head_owner      = tag_owner[rd_ptr];
        head_drop       = tag_drop[rd_ptr];
        iq_resp_valid_o = 1'b0;
        cm_resp_valid_o = 1'b0;
        dc_resp_ready_o = 1'b0;
        if (!fifo_empty) begin
            if (head_drop) begin
                dc_resp_ready_o = 1'b1;
            end else if (head_owner) begin
                cm_resp_valid_o = dc_resp_valid_i;
                dc_resp_ready_o = cm_resp_ready_i;
            end else begin
                iq_resp_valid_o = dc_resp_valid_i;
                dc_resp_ready_o = iq_resp_ready_i;
            end
        end
        pop    = dc_resp_valid_i && dc_resp_ready_o;
        resp_o = dc_resp_i;
        busy_o = (cnt != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_valid_o  <= 1'b0;
            dc_req_o    <= '0;
            stage_owner <= 1'b0;
            rr_q        <= 1'b0;
            tag_owner   <= '0;
            tag_drop    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
        end else begin
            if (grant) begin
                dc_valid_o  <= 1'b1;
                dc_req_o    <= winner ? cm_req_i : iq_req_i;
                stage_owner <= winner;
            end else if (dc_ready_i || cancel) begin
                dc_valid_o  <= 1'b0;
            end

            if (grant && iq_valid_i && cm_valid_i)
                rr_q <= ~winner;

            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);

            if (grant) begin
                tag_owner[wr_ptr] <= winner;
                tag_drop[wr_ptr]  <= 1'b0;
                wr_ptr            <= ptr_inc(wr_ptr);
            end else if (cancel) begin
                wr_ptr <= ptr_dec(wr_ptr);
            end

            // Grant is blocked during flush, so this never races the push above
            if (flush) begin
                for (int i = 0; i < MAX_OUTSTANDING; i++)
                    if (!tag_owner[i])
                        tag_drop[i] <= 1'b1;
            end

            cnt <= cnt + CNT_LEN'(grant) - CNT_LEN'(pop) - CNT_LEN'(cancel);
        end
    end

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
        dc_resp_valid_i |-> !fifo_empty);

endmodule

// File: tb/tb_lsu_dcache_arbiter.sv
// tb/tb_lsu_dcache_arbiter.sv - self-checking bench for lsu_dcache_arbiter
`timescale 1ns/1ps

module tb_lsu_dcache_arbiter;
    import lsu_dcache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush;
    logic        iq_valid_i, iq_ready_o;
    iq_lsu_pkg_t iq_req_i;
    logic        cm_valid_i, cm_ready_o;
    iq_lsu_pkg_t cm_req_i;
    logic        dc_valid_o, dc_ready_i;
    iq_lsu_pkg_t dc_req_o;
    logic        dc_resp_valid_i, dc_resp_ready_o;
    lsu_iq_pkg_t dc_resp_i;
    logic        iq_resp_valid_o, iq_resp_ready_i;
    logic        cm_resp_valid_o, cm_resp_ready_i;
    lsu_iq_pkg_t resp_o;
    logic        busy_o;

    int n_vec = 0;
    int n_err = 0;

    lsu_dcache_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .iq_valid_i(iq_valid_i), .iq_ready_o(iq_ready_o), .iq_req_i(iq_req_i),
        .cm_valid_i(cm_valid_i), .cm_ready_o(cm_ready_o), .cm_req_i(cm_req_i),
        .dc_valid_o(dc_valid_o), .dc_ready_i(dc_ready_i), .dc_req_o(dc_req_o),
        .dc_resp_valid_i(dc_resp_valid_i), .dc_resp_ready_o(dc_resp_ready_o), .dc_resp_i(dc_resp_i),
        .iq_resp_valid_o(iq_resp_valid_o), .iq_resp_ready_i(iq_resp_ready_i),
        .cm_resp_valid_o(cm_resp_valid_o), .cm_resp_ready_i(cm_resp_ready_i),
        .resp_o(resp_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got=running exp=finished");
        $fatal(1);
    end

    typedef struct { bit owner; bit drop; } tag_t;

    function automatic iq_lsu_pkg_t rand_req();
        iq_lsu_pkg_t r;
        r.vaddr    = $urandom;
        r.wdata    = $urandom;
        r.be       = 4'($urandom);
        r.is_store = 1'($urandom);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 0; iq_valid_i = 0; cm_valid_i = 0; dc_ready_i = 0;
        iq_req_i = '0; cm_req_i = '0;
        dc_resp_valid_i = 0; dc_resp_i = '0;
        iq_resp_ready_i = 0; cm_resp_ready_i = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (dc_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_dc_valid got=%b exp=0", dc_valid_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        n_vec++; if ({iq_resp_valid_o, cm_resp_valid_o} !== 2'b00) begin n_err++; $display("FAIL reset_resp_valids got=%b exp=00", {iq_resp_valid_o, cm_resp_valid_o}); end
        rst_n = 1;
        iq_valid_i = 1; cm_valid_i = 1; iq_req_i = rand_req(); cm_req_i = rand_req();
        #1;
        n_vec++; if ({iq_ready_o, cm_ready_o} !== 2'b10) begin n_err++; $display("FAIL reset_first_priority got=%b exp=10", {iq_ready_o, cm_ready_o}); end
        tick();
        clear_inputs();
    endtask

    task automatic test_single_load();
        iq_lsu_pkg_t r;
        do_reset();
        r = rand_req(); r.vaddr = 32'h1000; r.is_store = 0;
        iq_valid_i = 1; iq_req_i = r; dc_ready_i = 1;
        #1;
        n_vec++; if (iq_ready_o !== 1'b1) begin n_err++; $display("FAIL load_iq_ready got=%b exp=1", iq_ready_o); end
        tick();
        iq_valid_i = 0;
        #1;
        n_vec++; if (dc_valid_o !== 1'b1) begin n_err++; $display("FAIL load_dc_valid got=%b exp=1", dc_valid_o); end
        n_vec++; if (dc_req_o.vaddr !== 32'h1000) begin n_err++; $display("FAIL load_vaddr got=%h exp=00001000", dc_req_o.vaddr); end
        tick();
        dc_resp_valid_i = 1; dc_resp_i.rdata = 32'hDEADBEEF; dc_resp_i.err = 0; iq_resp_ready_i = 1;
        #1;
        n_vec++; if (iq_resp_valid_o !== 1'b1) begin n_err++; $display("FAIL load_iq_resp_valid got=%b exp=1", iq_resp_valid_o); end
        n_vec++; if (cm_resp_valid_o !== 1'b0) begin n_err++; $display("FAIL load_cm_resp_valid got=%b exp=0", cm_resp_valid_o); end
        n_vec++; if (resp_o.rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_rdata got=%h exp=deadbeef", resp_o.rdata); end
        n_vec++; if (dc_resp_ready_o !== 1'b1) begin n_err++; $display("FAIL load_resp_ready got=%b exp=1", dc_resp_ready_o); end
        tick();
        clear_inputs();
        #1;
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL load_busy_after got=%b exp=0", busy_o); end
    endtask

    task automatic test_arbitration();
        bit exp_iq[6] = '{1, 0, 1, 0, 0, 0};
        bit exp_cm[6] = '{0, 1, 0, 1, 0, 0};
        do_reset();
        iq_valid_i = 1; cm_valid_i = 1; dc_ready_i = 1;
        for (int c = 0; c < 6; c++) begin
            iq_req_i = rand_req(); cm_req_i = rand_req();
            #1;
            n_vec++; if (iq_ready_o !== exp_iq[c]) begin n_err++; $display("FAIL arb_iq_ready cyc=%0d got=%b exp=%b", c, iq_ready_o, exp_iq[c]); end
            n_vec++; if (cm_ready_o !== exp_cm[c]) begin n_err++; $display("FAIL arb_cm_ready cyc=%0d got=%b exp=%b", c, cm_ready_o, exp_cm[c]); end
            tick();
        end
        n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL arb_busy got=%b exp=1", busy_o); end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        iq_lsu_pkg_t a, b;
        do_reset();
        a = rand_req(); b = rand_req();
        iq_valid_i = 1; iq_req_i = a; dc_ready_i = 0;
        tick();
        iq_valid_i = 0; cm_valid_i = 1; cm_req_i = b;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++; if (dc_valid_o !== 1'b1 || dc_req_o !== a) begin n_err++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", c, dc_valid_o, dc_req_o, a); end
            n_vec++; if ({iq_ready_o, cm_ready_o} !== 2'b00) begin n_err++; $display("FAIL bp_no_grant cyc=%0d got=%b exp=00", c, {iq_ready_o, cm_ready_o}); end
            tick();
        end
        dc_ready_i = 1;
        #1;
        n_vec++; if (cm_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_refill_grant got=%b exp=1", cm_ready_o); end
        tick();
        cm_valid_i = 0; dc_ready_i = 0;
        #1;
        n_vec++; if (dc_valid_o !== 1'b1 || dc_req_o !== b) begin n_err++; $display("FAIL bp_refill_req got=%b/%h exp=1/%h", dc_valid_o, dc_req_o, b); end
        clear_inputs();
    endtask

    task automatic test_flush_drop();
        do_reset();
        dc_ready_i = 1;
        iq_valid_i = 1; iq_req_i = rand_req(); tick();
        iq_valid_i = 0; cm_valid_i = 1; cm_req_i = rand_req(); tick();
        cm_valid_i = 0; iq_valid_i = 1; iq_req_i = rand_req(); tick();
        iq_valid_i = 0; tick();
        dc_ready_i = 0; flush = 1; tick();
        flush = 0; cm_resp_ready_i = 1; iq_resp_ready_i = 0;
        for (int k = 0; k < 3; k++) begin
            dc_resp_valid_i = 1; dc_resp_i.rdata = $urandom; dc_resp_i.err = 0;
            #1;
            if (k == 1) begin
                n_vec++; if ({iq_resp_valid_o, cm_resp_valid_o} !== 2'b01) begin n_err++; $display("FAIL flush_cm_survives got=%b exp=01", {iq_resp_valid_o, cm_resp_valid_o}); end
            end else begin
                n_vec++; if ({iq_resp_valid_o, cm_resp_valid_o} !== 2'b00) begin n_err++; $display("FAIL flush_dropped_valids k=%0d got=%b exp=00", k, {iq_resp_valid_o, cm_resp_valid_o}); end
            end
            n_vec++; if (dc_resp_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_resp_ready k=%0d got=%b exp=1", k, dc_resp_ready_o); end
            tick();
        end
        dc_resp_valid_i = 0;
        #1;
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL flush_cnt_zero got=%b exp=0", busy_o); end
        clear_inputs();
    endtask

    task automatic test_flush_cancel();
        do_reset();
        iq_valid_i = 1; iq_req_i = rand_req(); dc_ready_i = 0;
        tick();
        flush = 1; iq_req_i = rand_req();
        #1;
        n_vec++; if (iq_ready_o !== 1'b0) begin n_err++; $display("FAIL cancel_no_grant got=%b exp=0", iq_ready_o); end
        tick();
        flush = 0; iq_valid_i = 0;
        #1;
        n_vec++; if (dc_valid_o !== 1'b0) begin n_err++; $display("FAIL cancel_dc_valid got=%b exp=0", dc_valid_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL cancel_cnt got=%b exp=0", busy_o); end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        dc_ready_i = 1; iq_valid_i = 1;
        repeat (3) begin iq_req_i = rand_req(); tick(); end
        iq_valid_i = 0; dc_ready_i = 0;
        #3 rst_n = 0;
        #1;
        n_vec++; if (dc_valid_o !== 1'b0) begin n_err++; $display("FAIL areset_dc_valid got=%b exp=0", dc_valid_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL areset_busy got=%b exp=0", busy_o); end
        tick();
        rst_n = 1;
        iq_valid_i = 1; iq_req_i = rand_req(); dc_ready_i = 1;
        #1;
        n_vec++; if (iq_ready_o !== 1'b1) begin n_err++; $display("FAIL areset_regrant got=%b exp=1", iq_ready_o); end
        tick();
        iq_valid_i = 0;
        #1;
        n_vec++; if (dc_valid_o !== 1'b1) begin n_err++; $display("FAIL areset_dc_valid_after got=%b exp=1", dc_valid_o); end
        clear_inputs();
    endtask

    task automatic test_random();
        tag_t        mq[$];
        tag_t        t;
        bit          m_st_valid, m_st_owner, m_rr;
        iq_lsu_pkg_t m_st_req;
        bit          g, w, e_iq_rdy, e_cm_rdy, e_iq_rv, e_cm_rv, e_rrdy;
        int          sent;
        do_reset();
        m_st_valid = 0; m_st_owner = 0; m_rr = 0; m_st_req = '0;
        for (int c = 0; c < 500; c++) begin
            iq_valid_i = 1'($urandom); iq_req_i = rand_req();
            cm_valid_i = 1'($urandom); cm_req_i = rand_req();
            dc_ready_i = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 19) == 0);
            sent = mq.size() - int'(m_st_valid);
            dc_resp_valid_i = (sent > 0) && ($urandom_range(0, 1) == 1);
            dc_resp_i.rdata = $urandom; dc_resp_i.err = 1'($urandom);
            iq_resp_ready_i = ($urandom_range(0, 9) < 8);
            cm_resp_ready_i = ($urandom_range(0, 9) < 8);
            #1;
            g = (!m_st_valid || dc_ready_i) && mq.size() < 4 && !flush && (iq_valid_i || cm_valid_i);
            w = (iq_valid_i && cm_valid_i) ? m_rr : cm_valid_i;
            e_iq_rdy = g && !w;
            e_cm_rdy = g && w;
            e_iq_rv = 0; e_cm_rv = 0; e_rrdy = 0;
            if (mq.size() > 0) begin
                if (mq[0].drop) e_rrdy = 1;
                else if (mq[0].owner) begin e_cm_rv = dc_resp_valid_i; e_rrdy = cm_resp_ready_i; end
                else begin e_iq_rv = dc_resp_valid_i; e_rrdy = iq_resp_ready_i; end
            end
            n_vec++; if (iq_ready_o !== e_iq_rdy) begin n_err++; $display("FAIL rnd_iq_ready cyc=%0d got=%b exp=%b", c, iq_ready_o, e_iq_rdy); end
            n_vec++; if (cm_ready_o !== e_cm_rdy) begin n_err++; $display("FAIL rnd_cm_ready cyc=%0d got=%b exp=%b", c, cm_ready_o, e_cm_rdy); end
            n_vec++; if (dc_valid_o !== m_st_valid) begin n_err++; $display("FAIL rnd_dc_valid cyc=%0d got=%b exp=%b", c, dc_valid_o, m_st_valid); end
            if (m_st_valid) begin
                n_vec++; if (dc_req_o !== m_st_req) begin n_err++; $display("FAIL rnd_dc_req cyc=%0d got=%h exp=%h", c, dc_req_o, m_st_req); end
            end
            n_vec++; if (busy_o !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy_o, mq.size() != 0); end
            n_vec++; if (iq_resp_valid_o !== e_iq_rv) begin n_err++; $display("FAIL rnd_iq_resp_valid cyc=%0d got=%b exp=%b", c, iq_resp_valid_o, e_iq_rv); end
            n_vec++; if (cm_resp_valid_o !== e_cm_rv) begin n_err++; $display("FAIL rnd_cm_resp_valid cyc=%0d got=%b exp=%b", c, cm_resp_valid_o, e_cm_rv); end
            if (mq.size() > 0) begin
                n_vec++; if (dc_resp_ready_o !== e_rrdy) begin n_err++; $display("FAIL rnd_resp_ready cyc=%0d got=%b exp=%b", c, dc_resp_ready_o, e_rrdy); end
            end
            n_vec++; if (resp_o !== dc_resp_i) begin n_err++; $display("FAIL rnd_resp_data cyc=%0d got=%h exp=%h", c, resp_o, dc_resp_i); end

            if (dc_resp_valid_i && e_rrdy) void'(mq.pop_front());
            if (flush && m_st_valid && !m_st_owner && !dc_ready_i) begin
                void'(mq.pop_back());
                m_st_valid = 0;
            end
            if (flush) foreach (mq[i]) if (!mq[i].owner) mq[i].drop = 1;
            if (m_st_valid && dc_ready_i) m_st_valid = 0;
            if (g) begin
                m_st_valid = 1; m_st_owner = w;
                m_st_req = w ? cm_req_i : iq_req_i;
                t.owner = w; t.drop = 0;
                mq.push_back(t);
                if (iq_valid_i && cm_valid_i) m_rr = !w;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_load();
        test_arbitration();
        test_backpressure();
        test_flush_drop();
        test_flush_cancel();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
